alu_issue: RTL and testbench



---
 rtl/alu_issue.sv | 257 +++++++++++++++++++++++++
 tb/tb_alu_issue.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// ============================================================================
// Module   : alu_issue
// Purpose  : Issue stage ahead of the ALU. Decodes RV32I OP, OP-IMM, BRANCH,
//            LUI and AUIPC into an aluop/src0/src1 micro-op and registers it
//            behind a valid/ready handshake, optionally with a skid entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue #(
  parameter int SKID = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_aluop,
  output logic [31:0] out_src0,
  output logic [31:0] out_src1,
  output logic        out_is_branch,
  output logic [31:0] out_target,
  output logic [4:0]  out_rd,
  output logic        out_wb_en,
  output logic        out_illegal
);

  // ALU opcodes; branch codes are chosen so that ALU flag (result==0) = taken.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_BNE = 4'b1001;
  localparam logic [3:0] ALU_BLT = 4'b1010;
  localparam logic [3:0] ALU_BGE = 4'b1011;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  aluop;
    logic [31:0] src0;
    logic [31:0] src1;
    logic        is_branch;
    logic [31:0] target;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
  } uop_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] imm_b;
  logic [31:0] shamt;
  uop_t        dec;
  logic        in_xfer;
  uop_t        out_q;
  logic        out_valid_q;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
  assign shamt  = {27'b0, in_instr[24:20]};

  // Decode the incoming instruction into a micro-op; illegal encodings are
  // squashed to a harmless ADD 0,0 with no writeback and no branch.
  always_comb begin
    logic [3:0]  aluop;
    logic [31:0] src0;
    logic [31:0] src1;
    logic        is_branch;
    logic        wb_cand;
    logic        illegal;
    aluop     = ALU_ADD;
    src0      = 32'b0;
    src1      = 32'b0;
    is_branch = 1'b0;
    wb_cand   = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        src0    = in_rs1_data;
        src1    = in_rs2_data;
        wb_cand = 1'b1;
        case (funct3)
          3'b000: begin
            if (funct7 == F7_BASE)     aluop = ALU_ADD;
            else if (funct7 == F7_ALT) aluop = ALU_SUB;
            else                       illegal = 1'b1;
          end
          3'b001: begin aluop = ALU_SLL; illegal = (funct7 != F7_BASE); end
          3'b010: begin aluop = ALU_SLT; illegal = (funct7 != F7_BASE); end
          3'b100: begin aluop = ALU_XOR; illegal = (funct7 != F7_BASE); end
          3'b101: begin
            if (funct7 == F7_BASE)     aluop = ALU_SRL;
            else if (funct7 == F7_ALT) aluop = ALU_SRA;
            else                       illegal = 1'b1;
          end
          3'b110: begin aluop = ALU_OR;  illegal = (funct7 != F7_BASE); end
          3'b111: begin aluop = ALU_AND; illegal = (funct7 != F7_BASE); end
          default: illegal = 1'b1;  // SLTU is not supported by the ALU
        endcase
      end
      OPC_OP_IMM: begin
        src0    = in_rs1_data;
        src1    = imm_i;
        wb_cand = 1'b1;
        case (funct3)
          3'b000: aluop = ALU_ADD;
          3'b010: aluop = ALU_SLT;
          3'b100: aluop = ALU_XOR;
          3'b110: aluop = ALU_OR;
          3'b111: aluop = ALU_AND;
          3'b001: begin
            src1    = shamt;
            aluop   = ALU_SLL;
            illegal = (funct7 != F7_BASE);
          end
          3'b101: begin
            src1 = shamt;
            if (funct7 == F7_BASE)     aluop = ALU_SRL;
            else if (funct7 == F7_ALT) aluop = ALU_SRA;
            else                       illegal = 1'b1;
          end
          default: illegal = 1'b1;  // SLTIU
        endcase
      end
      OPC_LUI: begin
        src1    = imm_u;
        wb_cand = 1'b1;
      end
      OPC_AUIPC: begin
        src0    = in_pc;
        src1    = imm_u;
        wb_cand = 1'b1;
      end
      OPC_BRANCH: begin
        src0      = in_rs1_data;
        src1      = in_rs2_data;
        is_branch = 1'b1;
        case (funct3)
          3'b000:  aluop = ALU_SUB;   // BEQ: difference is zero when taken
          3'b001:  aluop = ALU_BNE;
          3'b100:  aluop = ALU_BLT;
          3'b101:  aluop = ALU_BGE;
          default: illegal = 1'b1;    // unsigned compares unsupported
        endcase
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      aluop     = ALU_ADD;
      src0      = 32'b0;
      src1      = 32'b0;
      is_branch = 1'b0;
      wb_cand   = 1'b0;
    end

    dec.aluop     = aluop;
    dec.src0      = src0;
    dec.src1      = src1;
    dec.is_branch = is_branch;
    dec.target    = in_pc + imm_b;
    dec.rd        = in_instr[11:7];
    dec.wb_en     = wb_cand & (in_instr[11:7] != 5'd0);
    dec.illegal   = illegal;
  end

  assign in_xfer = in_valid & in_ready;

  generate
    if (SKID != 0) begin : g_skid
      uop_t skid_q;
      logic skid_valid_q;

      // in_ready comes straight from a flop so it never depends on out_ready.
      assign in_ready = ~skid_valid_q;

      // Output register with one skid entry catching the word accepted
      // while the output is stalled; the skid drains first to keep order.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_q        <= '0;
          out_valid_q  <= 1'b0;
          skid_q       <= '0;
          skid_valid_q <= 1'b0;
        end else if (~out_valid_q | out_ready) begin
          if (skid_valid_q) begin
            out_q        <= skid_q;
            out_valid_q  <= 1'b1;
            skid_valid_q <= 1'b0;
          end else if (in_xfer) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
          end else begin
            out_valid_q <= 1'b0;
          end
        end else if (in_xfer) begin
          skid_q       <= dec;
          skid_valid_q <= 1'b1;
        end
      end
    end else begin : g_noskid
      assign in_ready = ~out_valid_q | out_ready;

      // Single output register: load on accept, clear once consumed.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_q       <= '0;
          out_valid_q <= 1'b0;
        end else if (in_xfer) begin
          out_q       <= dec;
          out_valid_q <= 1'b1;
        end else if (out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  endgenerate

  assign out_valid     = out_valid_q;
  assign out_aluop     = out_q.aluop;
  assign out_src0      = out_q.src0;
  assign out_src1      = out_q.src1;
  assign out_is_branch = out_q.is_branch;
  assign out_target    = out_q.target;
  assign out_rd        = out_q.rd;
  assign out_wb_en     = out_q.wb_en;
  assign out_illegal   = out_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// ============================================================================
// Module   : tb_alu_issue
// Purpose  : Directed self-checking bench for alu_issue; one instance with
//            the skid buffer, one without, selected by 'sel'.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue;

  localparam int NV = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        v;
  logic        rdy;
  logic [31:0] instr, pc, rs1, rs2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Instance A: SKID=1, instance B: SKID=0. The idle one is drained.
  wire va = v & ~sel;
  wire vb = v & sel;
  wire ra = sel ? 1'b1 : rdy;
  wire rb = sel ? rdy : 1'b1;

  logic        ir_a, ov_a, br_a, wb_a, il_a;
  logic [3:0]  op_a;
  logic [31:0] s0_a, s1_a, tg_a;
  logic [4:0]  rd_a;
  logic        ir_b, ov_b, br_b, wb_b, il_b;
  logic [3:0]  op_b;
  logic [31:0] s0_b, s1_b, tg_b;
  logic [4:0]  rd_b;

  alu_issue #(.SKID(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(va), .in_ready(ir_a),
    .in_instr(instr), .in_pc(pc), .in_rs1_data(rs1), .in_rs2_data(rs2),
    .out_valid(ov_a), .out_ready(ra), .out_aluop(op_a), .out_src0(s0_a),
    .out_src1(s1_a), .out_is_branch(br_a), .out_target(tg_a), .out_rd(rd_a),
    .out_wb_en(wb_a), .out_illegal(il_a)
  );

  alu_issue #(.SKID(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_ready(ir_b),
    .in_instr(instr), .in_pc(pc), .in_rs1_data(rs1), .in_rs2_data(rs2),
    .out_valid(ov_b), .out_ready(rb), .out_aluop(op_b), .out_src0(s0_b),
    .out_src1(s1_b), .out_is_branch(br_b), .out_target(tg_b), .out_rd(rd_b),
    .out_wb_en(wb_b), .out_illegal(il_b)
  );

  // {aluop, src0, src1, is_branch, target, rd, wb_en, illegal}
  wire [107:0] pk_a = {op_a, s0_a, s1_a, br_a, tg_a, rd_a, wb_a, il_a};
  wire [107:0] pk_b = {op_b, s0_b, s1_b, br_b, tg_b, rd_b, wb_b, il_b};
  wire [107:0] obs_pk    = sel ? pk_b : pk_a;
  wire         obs_valid = sel ? ov_b : ov_a;
  wire         obs_ir    = sel ? ir_b : ir_a;

  logic [31:0]  t_instr [NV];
  logic [31:0]  t_pc    [NV];
  logic [31:0]  t_rs1   [NV];
  logic [31:0]  t_rs2   [NV];
  logic [107:0] t_exp   [NV];

  function automatic logic [107:0] mk(input logic [3:0] op, input logic [31:0] s0,
                                      input logic [31:0] s1, input logic br,
                                      input logic [31:0] tg, input logic [4:0] rd,
                                      input logic wb, input logic il);
    return {op, s0, s1, br, tg, rd, wb, il};
  endfunction

  task automatic setv(input int i, input logic [31:0] ins, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b, input logic [107:0] e);
    t_instr[i] = ins; t_pc[i] = p; t_rs1[i] = a; t_rs2[i] = b; t_exp[i] = e;
  endtask

  // Hand-encoded instructions with hand-computed micro-ops.
  task automatic load_vectors();
    setv(0,  32'h002081B3, 32'h1000, 32'h5, 32'hFFFFFFFD,          // ADD x3,x1,x2
         mk(4'h0, 32'h5, 32'hFFFFFFFD, 0, 32'h1802, 5'd3, 1, 0));
    setv(1,  32'h4070D213, 32'h2000, 32'h80000000, 32'h0,          // SRAI x4,x1,7
         mk(4'h8, 32'h80000000, 32'h7, 0, 32'h2404, 5'd4, 1, 0));
    setv(2,  32'hFFF30293, 32'h3000, 32'h1234, 32'h0,              // ADDI x5,x6,-1
         mk(4'h0, 32'h1234, 32'hFFFFFFFF, 0, 32'h2FE4, 5'd5, 1, 0));
    setv(3,  32'hFE208CE3, 32'h100, 32'h9, 32'h9,                  // BEQ -8
         mk(4'h1, 32'h9, 32'h9, 1, 32'hF8, 5'd25, 0, 0));
    setv(4,  32'hFE20DCE3, 32'h100, 32'h3, 32'h7,                  // BGE -8
         mk(4'hB, 32'h3, 32'h7, 1, 32'hF8, 5'd25, 0, 0));
    setv(5,  32'hFE20ECE3, 32'h100, 32'h3, 32'h7,                  // BLTU: illegal
         mk(4'h0, 32'h0, 32'h0, 0, 32'hF8, 5'd25, 0, 1));
    setv(6,  32'hABCDE3B7, 32'h40, 32'h11, 32'h22,                 // LUI x7
         mk(4'h0, 32'h0, 32'hABCDE000, 0, 32'hFFFFFAE6, 5'd7, 1, 0));
    setv(7,  32'h00001017, 32'h80000000, 32'h1, 32'h2,             // AUIPC x0
         mk(4'h0, 32'h80000000, 32'h1000, 0, 32'h80000000, 5'd0, 0, 0));
    setv(8,  32'h40C58533, 32'h0, 32'h64, 32'h1E,                  // SUB x10
         mk(4'h1, 32'h64, 32'h1E, 0, 32'h40A, 5'd10, 1, 0));
    setv(9,  32'h0020B1B3, 32'h1000, 32'h5, 32'h6,                 // SLTU: illegal
         mk(4'h0, 32'h0, 32'h0, 0, 32'h1802, 5'd3, 0, 1));
    setv(10, 32'h00000073, 32'h44, 32'h5, 32'h6,                   // ECALL: illegal
         mk(4'h0, 32'h0, 32'h0, 0, 32'h44, 5'd0, 0, 1));
    setv(11, 32'h003160B3, 32'h10, 32'hF0, 32'h0F,                 // OR x1
         mk(4'h5, 32'hF0, 32'hF, 0, 32'h810, 5'd1, 1, 0));
    setv(12, 32'h40309113, 32'h0, 32'h5, 32'h6,                    // SLLI bad f7
         mk(4'h0, 32'h0, 32'h0, 0, 32'h402, 5'd2, 0, 1));
    setv(13, 32'h0050A113, 32'h0, 32'hFFFFFFFF, 32'h0,             // SLTI x2,x1,5
         mk(4'h2, 32'hFFFFFFFF, 32'h5, 0, 32'h2, 5'd2, 1, 0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int i);
    instr = t_instr[i]; pc = t_pc[i]; rs1 = t_rs1[i]; rs2 = t_rs2[i];
  endtask

  task automatic chk_uop(input string name, input logic [107:0] exp);
    nvec++;
    if (obs_valid !== 1'b1 || obs_pk !== exp) begin
      nerr++;
      $display("FAIL %s: got valid=%b uop=%h, want valid=1 uop=%h", name, obs_valid, obs_pk, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b, want %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0; v = 1'b0; rdy = 1'b1; rst = 1'b1;
    apply(0);
    tick(); tick();
    chk_bit("reset_out_valid", obs_valid, 1'b0);
    nvec++;
    if (obs_pk !== 108'b0) begin
      nerr++; $display("FAIL reset_fields: got %h, want 0", obs_pk);
    end
    rst = 1'b0;
    tick();
    chk_bit("reset_in_ready_a", ir_a, 1'b1);
    chk_bit("reset_in_ready_b", ir_b, 1'b1);
  endtask

  task automatic test_decode();
    sel = 1'b0; rdy = 1'b1;
    for (int i = 0; i < NV; i++) begin
      apply(i); v = 1'b1;
      tick();
      v = 1'b0;
      chk_uop($sformatf("decode_%0d", i), t_exp[i]);
    end
    tick();
    chk_bit("decode_idle_valid", obs_valid, 1'b0);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply(i + 6); v = 1'b1;
      tick();
      chk_uop($sformatf("b2b_%0d", i), t_exp[i + 6]);
    end
    v = 1'b0;
    tick();
  endtask

  task automatic test_skid();
    sel = 1'b0; rdy = 1'b0;
    apply(0); v = 1'b1;
    tick();
    chk_uop("skid_first_out", t_exp[0]);
    chk_bit("skid_ready_after_first", obs_ir, 1'b1);
    apply(1);
    tick();
    chk_bit("skid_full_ready", obs_ir, 1'b0);
    chk_uop("skid_hold_first", t_exp[0]);
    apply(2);
    tick();
    chk_bit("skid_third_blocked", obs_ir, 1'b0);
    chk_uop("skid_hold_again", t_exp[0]);
    rdy = 1'b1;
    tick();
    chk_uop("skid_second_out", t_exp[1]);
    chk_bit("skid_ready_reopen", obs_ir, 1'b1);
    tick();
    v = 1'b0;
    chk_uop("skid_third_out", t_exp[2]);
    tick();
    chk_bit("skid_drained", obs_valid, 1'b0);
  endtask

  task automatic test_noskid();
    sel = 1'b1; rdy = 1'b0;
    apply(5); v = 1'b1;
    tick();
    chk_uop("noskid_first", t_exp[5]);
    chk_bit("noskid_stall_ready", obs_ir, 1'b0);
    rdy = 1'b1;
    #1;
    chk_bit("noskid_comb_ready", obs_ir, 1'b1);
    apply(6);
    tick();
    chk_uop("noskid_simultaneous", t_exp[6]);
    v = 1'b0;
    tick();
    chk_bit("noskid_drained", obs_valid, 1'b0);
  endtask

  task automatic test_reset_midstream();
    sel = 1'b0; rdy = 1'b0;
    apply(1); v = 1'b1;
    tick();
    apply(3);
    tick();
    v = 1'b0;
    chk_bit("mid_skid_full", obs_ir, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_bit("mid_async_clear", obs_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy = 1'b1;
    tick();
    chk_bit("mid_ready_after", obs_ir, 1'b1);
    chk_bit("mid_valid_after", obs_valid, 1'b0);
    nvec++;
    if (obs_pk !== 108'b0) begin
      nerr++; $display("FAIL mid_fields_zero: got %h, want 0", obs_pk);
    end
  endtask

  // Random valid/ready traffic drawn from the vector table; every issued
  // micro-op must match the next accepted entry, and stalled outputs hold.
  task automatic test_stream(input logic s, input int ncyc);
    int q[$];
    logic stall_prev;
    logic [107:0] snap;
    int k;
    int idx;
    sel = s; v = 1'b0; rdy = 1'b0;
    stall_prev = 1'b0; snap = '0;
    for (int c = 0; c < ncyc + 12; c++) begin
      if (stall_prev) begin
        nvec++;
        if (obs_valid !== 1'b1 || obs_pk !== snap) begin
          nerr++;
          $display("FAIL stream%0d_hold: got valid=%b uop=%h, want valid=1 uop=%h", s, obs_valid, obs_pk, snap);
        end
      end
      k = $urandom_range(0, NV - 1);
      apply(k);
      if (c < ncyc) begin
        rdy = ($urandom_range(0, 9) < 6);
        v   = ($urandom_range(0, 9) < 7);
      end else begin
        rdy = 1'b1;
        v   = 1'b0;
      end
      #1;
      if (obs_valid && rdy) begin
        nvec++;
        if (q.size() == 0) begin
          nerr++;
          $display("FAIL stream%0d_extra: got uop=%h, want nothing", s, obs_pk);
        end else begin
          idx = q.pop_front();
          if (obs_pk !== t_exp[idx]) begin
            nerr++;
            $display("FAIL stream%0d_order: got %h, want %h", s, obs_pk, t_exp[idx]);
          end
        end
      end
      if (v && obs_ir) q.push_back(k);
      stall_prev = obs_valid && !rdy;
      snap = obs_pk;
      @(posedge clk);
      #1;
    end
    v = 1'b0;
    nvec++;
    if (q.size() != 0 || obs_valid !== 1'b0) begin
      nerr++;
      $display("FAIL stream%0d_drain: got %0d pending valid=%b, want 0 pending valid=0", s, q.size(), obs_valid);
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; v = 1'b0; rdy = 1'b0;
    instr = '0; pc = '0; rs1 = '0; rs2 = '0;
    load_vectors();
    test_reset();
    test_decode();
    test_back_to_back();
    test_skid();
    test_noskid();
    test_reset_midstream();
    test_stream(1'b0, 4000);
    test_stream(1'b1, 4000);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
